// File: rtl/dsocm_bram_port_arbiter_if.sv
// rtl/dsocm_bram_port_arbiter_if.sv - requester and BRAM port bundle for the DSOCM BRAM port arbiter
interface dsocm_bram_port_arbiter_if #(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4
);
  // requester M0
  logic                     m0_req;
  logic                     m0_lock;
  logic [C_NUM_WE-1:0]      m0_we;
  logic [C_PORT_AWIDTH-1:0] m0_addr;
  logic [C_PORT_DWIDTH-1:0] m0_wrdata;
  logic                     m0_ack;
  logic [C_PORT_DWIDTH-1:0] m0_rddata;
  logic                     m0_rdvalid;
  // requester M1
  logic                     m1_req;
  logic                     m1_lock;
  logic [C_NUM_WE-1:0]      m1_we;
  logic [C_PORT_AWIDTH-1:0] m1_addr;
  logic [C_PORT_DWIDTH-1:0] m1_wrdata;
  logic                     m1_ack;
  logic [C_PORT_DWIDTH-1:0] m1_rddata;
  logic                     m1_rdvalid;
  // shared BRAM port
  logic                     bram_clk;
  logic                     bram_rst;
  logic                     bram_en;
  logic [C_NUM_WE-1:0]      bram_wen;
  logic [C_PORT_AWIDTH-1:0] bram_addr;
  logic [C_PORT_DWIDTH-1:0] bram_dout;
  logic [C_PORT_DWIDTH-1:0] bram_din;

  // requesters and the BRAM itself
  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wrdata,
    input  m0_ack, m0_rddata, m0_rdvalid,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wrdata,
    input  m1_ack, m1_rddata, m1_rdvalid,
    input  bram_clk, bram_rst, bram_en, bram_wen, bram_addr, bram_dout,
    output bram_din
  );

  // the arbiter
  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wrdata,
    output m0_ack, m0_rddata, m0_rdvalid,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wrdata,
    output m1_ack, m1_rddata, m1_rdvalid,
    output bram_clk, bram_rst, bram_en, bram_wen, bram_addr, bram_dout,
    input  bram_din
  );
endinterface

// File: rtl/dsocm_bram_port_arbiter.sv
// rtl/dsocm_bram_port_arbiter.sv - round-robin arbiter with lock and watchdog sharing one DSOCM BRAM port
module dsocm_bram_port_arbiter #(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_LOCK_MAX    = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  dsocm_bram_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(C_LOCK_MAX + 1);
  localparam logic [CW-1:0] LP_CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LP_CNT_FORCE = CW'(C_LOCK_MAX - 1);
  // a single-grant lock budget means a lock can never actually be held
  localparam logic LP_CAN_LOCK = (C_LOCK_MAX > 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_t;

  state_t                   r_state;
  logic                     r_rr;        // 0 favours M0, 1 favours M1
  logic [CW-1:0]            r_cnt;
  logic                     r_bram_en;
  logic [C_NUM_WE-1:0]      r_bram_wen;
  logic [C_PORT_AWIDTH-1:0] r_bram_addr;
  logic [C_PORT_DWIDTH-1:0] r_bram_dout;
  logic                     r_t1_rd;     // read issued to BRAM this cycle
  logic                     r_t1_own;    // owner of that read (1 = M1)
  logic                     r_m0_rdvalid;
  logic                     r_m1_rdvalid;

  logic                     w_grant0;
  logic                     w_grant1;
  logic                     w_any;
  logic                     w_gnt_lock;
  logic                     w_forced;
  logic [C_NUM_WE-1:0]      w_we;

  // pick at most one winner; a locked state only ever serves its owner
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          w_grant0 = !r_rr;
          w_grant1 = r_rr;
        end else begin
          w_grant0 = bus.m0_req;
          w_grant1 = bus.m1_req;
        end
      end
      S_LOCK0: w_grant0 = bus.m0_req;
      S_LOCK1: w_grant1 = bus.m1_req;
      default: ;
    endcase
  end

  assign w_any      = w_grant0 | w_grant1;
  assign w_gnt_lock = w_grant1 ? bus.m1_lock : bus.m0_lock;
  assign w_we       = w_grant1 ? bus.m1_we : bus.m0_we;
  // this grant is the last one the lock budget allows
  assign w_forced   = (r_cnt >= LP_CNT_FORCE);

  // ownership FSM: round-robin pointer, lock tracking and watchdog release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_rr <= w_grant0;
            if (w_gnt_lock && LP_CAN_LOCK) begin
              r_state <= w_grant0 ? S_LOCK0 : S_LOCK1;
              r_cnt   <= LP_CNT_ONE;
            end
          end
        end
        S_LOCK0: begin
          if ((w_grant0 && (!bus.m0_lock || w_forced)) || (!bus.m0_req && !bus.m0_lock)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rr    <= 1'b1;
          end else if (w_grant0) begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        S_LOCK1: begin
          if ((w_grant1 && (!bus.m1_lock || w_forced)) || (!bus.m1_req && !bus.m1_lock)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rr    <= 1'b0;
          end else if (w_grant1) begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // BRAM port registers and the owner/read tag pipeline for the valid strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bram_en    <= 1'b0;
      r_bram_wen   <= '0;
      r_bram_addr  <= '0;
      r_bram_dout  <= '0;
      r_t1_rd      <= 1'b0;
      r_t1_own     <= 1'b0;
      r_m0_rdvalid <= 1'b0;
      r_m1_rdvalid <= 1'b0;
    end else begin
      r_bram_en    <= w_any;
      r_bram_wen   <= w_any ? w_we : '0;
      if (w_any) begin
        r_bram_addr <= w_grant1 ? bus.m1_addr : bus.m0_addr;
        r_bram_dout <= w_grant1 ? bus.m1_wrdata : bus.m0_wrdata;
      end
      r_t1_rd      <= w_any && (w_we == '0);
      r_t1_own     <= w_grant1;
      r_m0_rdvalid <= r_t1_rd && !r_t1_own;
      r_m1_rdvalid <= r_t1_rd && r_t1_own;
    end
  end

  assign bus.m0_ack     = w_grant0;
  assign bus.m1_ack     = w_grant1;
  assign bus.m0_rddata  = bus.bram_din;
  assign bus.m1_rddata  = bus.bram_din;
  assign bus.m0_rdvalid = r_m0_rdvalid;
  assign bus.m1_rdvalid = r_m1_rdvalid;
  assign bus.bram_clk   = i_clk;
  assign bus.bram_rst   = 1'b0;
  assign bus.bram_en    = r_bram_en;
  assign bus.bram_wen   = r_bram_wen;
  assign bus.bram_addr  = r_bram_addr;
  assign bus.bram_dout  = r_bram_dout;
endmodule

// File: tb/tb_dsocm_bram_port_arbiter.sv
// tb/tb_dsocm_bram_port_arbiter.sv - directed self-checking bench for dsocm_bram_port_arbiter
module tb_dsocm_bram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [31:0] mem [0:255];
  logic [31:0] din;

  always #5 clk = ~clk;

  dsocm_bram_port_arbiter_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) bus ();
  dsocm_bram_port_arbiter_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) bus4 ();

  dsocm_bram_port_arbiter #(.C_LOCK_MAX(16)) u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  dsocm_bram_port_arbiter #(.C_LOCK_MAX(4))  u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));

  assign bus.bram_din  = din;
  assign bus4.bram_din = 32'h0;

  // BRAM behavioural model: byte-write, registered read
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.bram_wen[b]) mem[bus.bram_addr[9:2]][8*b +: 8] <= bus.bram_dout[8*b +: 8];
      end else begin
        din <= mem[bus.bram_addr[9:2]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wrdata = 0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wrdata = 0;
    bus4.m0_req = 0; bus4.m0_lock = 0; bus4.m0_we = 0; bus4.m0_addr = 0; bus4.m0_wrdata = 0;
    bus4.m1_req = 0; bus4.m1_lock = 0; bus4.m1_we = 0; bus4.m1_addr = 0; bus4.m1_wrdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (bus.bram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_en got %0b want 0", bus.bram_en); end
    tests_run++;
    if ({bus.bram_wen, bus.bram_addr, bus.bram_dout} !== 68'h0) begin
      tests_failed++; $display("FAIL reset_bus got wen=%h addr=%h dout=%h want 0", bus.bram_wen, bus.bram_addr, bus.bram_dout);
    end
    tests_run++;
    if ({bus.m1_rdvalid, bus.m0_rdvalid} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_rdvalid got %b want 00", {bus.m1_rdvalid, bus.m0_rdvalid});
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h100;
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin tests_failed++; $display("FAIL t1_ack got %b want 01", {bus.m1_ack, bus.m0_ack}); end
    step();
    bus.m0_req = 0;
    @(negedge clk);
    tests_run++;
    if (bus.bram_en !== 1'b1 || bus.bram_addr !== 32'h100 || bus.bram_wen !== 4'b0000) begin
      tests_failed++; $display("FAIL t1_port got en=%b addr=%h wen=%b want 1 100 0000", bus.bram_en, bus.bram_addr, bus.bram_wen);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (bus.m0_rdvalid !== 1'b1 || bus.m1_rdvalid !== 1'b0) begin
      tests_failed++; $display("FAIL t1_rdvalid got m0=%b m1=%b want 1 0", bus.m0_rdvalid, bus.m1_rdvalid);
    end
    tests_run++;
    if (bus.m0_rddata !== 32'h11223340) begin tests_failed++; $display("FAIL t1_rddata got %h want 11223340", bus.m0_rddata); end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h0;
    bus.m1_req = 1; bus.m1_addr = 32'h4;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.m1_ack, bus.m0_ack} !== ((i % 2) ? 2'b10 : 2'b01)) begin
        tests_failed++; $display("FAIL t2_ack[%0d] got %b want %b", i, {bus.m1_ack, bus.m0_ack}, ((i % 2) ? 2'b10 : 2'b01));
      end
      if (i > 0) begin
        tests_run++;
        if (bus.bram_en !== 1'b1) begin tests_failed++; $display("FAIL t2_en[%0d] got %b want 1", i, bus.bram_en); end
      end
      step();
    end
    bus.m0_req = 0; bus.m1_req = 0;
    step(); step();
  endtask

  task automatic test_partial_write();
    do_reset();
    bus.m1_req = 1; bus.m1_we = 4'b1000; bus.m1_addr = 32'h40; bus.m1_wrdata = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b10) begin tests_failed++; $display("FAIL t3_wack got %b want 10", {bus.m1_ack, bus.m0_ack}); end
    step();
    bus.m1_req = 0; bus.m1_we = 0;
    bus.m0_req = 1; bus.m0_addr = 32'h40;
    @(negedge clk);
    tests_run++;
    if (bus.bram_wen !== 4'b1000 || bus.bram_dout !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL t3_write got wen=%b dout=%h want 1000 deadbeef", bus.bram_wen, bus.bram_dout);
    end
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin tests_failed++; $display("FAIL t3_rack got %b want 01", {bus.m1_ack, bus.m0_ack}); end
    step();
    bus.m0_req = 0;
    @(negedge clk);
    tests_run++;
    if (bus.m1_rdvalid !== 1'b0 || bus.bram_wen !== 4'b0000 || bus.bram_en !== 1'b1) begin
      tests_failed++; $display("FAIL t3_noval got rdv1=%b wen=%b en=%b want 0 0000 1", bus.m1_rdvalid, bus.bram_wen, bus.bram_en);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (bus.m0_rdvalid !== 1'b1 || bus.m0_rddata !== 32'hDE223310) begin
      tests_failed++; $display("FAIL t3_read got v=%b data=%h want 1 de223310", bus.m0_rdvalid, bus.m0_rddata);
    end
    step();
  endtask

  task automatic test_lock();
    do_reset();
    bus.m0_req = 1; bus.m0_lock = 1; bus.m0_addr = 32'h8;
    bus.m1_req = 1; bus.m1_addr = 32'hC;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.m0_lock = 0;
      @(negedge clk);
      tests_run++;
      if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin
        tests_failed++; $display("FAIL t4_ack[%0d] got %b want 01", i, {bus.m1_ack, bus.m0_ack});
      end
      step();
    end
    bus.m0_req = 0;
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b10) begin tests_failed++; $display("FAIL t4_release got %b want 10", {bus.m1_ack, bus.m0_ack}); end
    step();
    bus.m1_req = 0;
    step(); step();
  endtask

  task automatic test_lock_hold();
    do_reset();
    bus.m0_req = 1; bus.m0_lock = 1;
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin tests_failed++; $display("FAIL hold_first got %b want 01", {bus.m1_ack, bus.m0_ack}); end
    step();
    bus.m0_req = 0; bus.m1_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.m1_ack, bus.m0_ack} !== 2'b00) begin
        tests_failed++; $display("FAIL hold_ack[%0d] got %b want 00", i, {bus.m1_ack, bus.m0_ack});
      end
      if (i == 1) begin
        tests_run++;
        if (bus.bram_en !== 1'b0) begin tests_failed++; $display("FAIL hold_en got %b want 0", bus.bram_en); end
      end
      step();
    end
    bus.m0_lock = 0;
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b00) begin tests_failed++; $display("FAIL hold_exit got %b want 00", {bus.m1_ack, bus.m0_ack}); end
    step();
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b10) begin tests_failed++; $display("FAIL hold_m1 got %b want 10", {bus.m1_ack, bus.m0_ack}); end
    step();
    bus.m1_req = 0;
    step(); step();
  endtask

  task automatic test_watchdog();
    logic [1:0] exp_ack [0:9];
    exp_ack = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    bus4.m0_req = 1; bus4.m0_lock = 1; bus4.m0_addr = 32'h10;
    bus4.m1_req = 1; bus4.m1_addr = 32'h14;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus4.m1_ack, bus4.m0_ack} !== exp_ack[i]) begin
        tests_failed++; $display("FAIL t5_ack[%0d] got %b want %b", i, {bus4.m1_ack, bus4.m0_ack}, exp_ack[i]);
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h100;
    @(negedge clk);
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin tests_failed++; $display("FAIL t6_ack got %b want 01", {bus.m1_ack, bus.m0_ack}); end
    step();
    rst_n = 0;
    bus.m0_req = 0;
    @(negedge clk);
    tests_run++;
    if (bus.bram_en !== 1'b0 || bus.bram_addr !== 32'h0 || bus.m0_rdvalid !== 1'b0) begin
      tests_failed++; $display("FAIL t6_inreset got en=%b addr=%h rdv=%b want 0 0 0", bus.bram_en, bus.bram_addr, bus.m0_rdvalid);
    end
    step();
    rst_n = 1;
    bus.m0_req = 1; bus.m0_addr = 32'h0;
    bus.m1_req = 1; bus.m1_addr = 32'h4;
    @(negedge clk);
    tests_run++;
    if (bus.m0_rdvalid !== 1'b0 || bus.bram_en !== 1'b0) begin
      tests_failed++; $display("FAIL t6_dropped got rdv=%b en=%b want 0 0", bus.m0_rdvalid, bus.bram_en);
    end
    tests_run++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin tests_failed++; $display("FAIL t6_first got %b want 01", {bus.m1_ack, bus.m0_ack}); end
    step();
    clear_inputs();
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h11223300 | i;
    din = 32'h0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_partial_write();
    test_lock();
    test_lock_hold();
    test_watchdog();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
